// File: rtl/med_seq.sv
// Sequencing controller for the shift-register / compare-exchange median datapath.
// Drives DSI/BYP through load, N-cycle sort passes and a final pass; flags DSO when DO is the median.
module med_seq #(
    parameter int N = 9
) (
    input  logic CLK,
    input  logic RST,
    input  logic DSI,
    output logic MED_DSI,
    output logic MED_BYP,
    output logic DSO,
    output logic BUSY,
    output logic ERR,
    output logic OVR
);

    localparam int P  = (N - 1) / 2;
    localparam int CW = $clog2(N + 1);
    localparam int PW = $clog2(P + 1);

    localparam logic [CW-1:0] CYC_LOAD_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CYC_FIN_LAST  = CW'(P - 1);
    localparam logic [PW-1:0] PASS_LAST     = PW'(P - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CMP  = 3'd2,
        S_SHF  = 3'd3,
        S_FIN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;
    logic [CW-1:0] cmp_last_s;
    logic [CW-1:0] shf_last_s;

    // Pass p compares N-1-p cycles and shifts p+1 cycles, so every pass is exactly N cycles.
    assign cmp_last_s = CW'(N - 2) - CW'(pass_q);
    assign shf_last_s = CW'(pass_q);

    // State, counter and flag registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            pass_q  <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        pass_d  = pass_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                pass_d = '0;
                if (DSI) begin
                    state_d = S_LOAD;
                    cyc_d   = CW'(1);
                end else begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end
            end
            S_LOAD: begin
                if (!DSI) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                    err_d   = 1'b1;
                end else if (cyc_q == CYC_LOAD_LAST) begin
                    state_d = S_CMP;
                    cyc_d   = '0;
                    pass_d  = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_CMP: begin
                ovr_d = DSI;
                if (cyc_q == cmp_last_s) begin
                    state_d = S_SHF;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_SHF: begin
                ovr_d = DSI;
                if (cyc_q == shf_last_s) begin
                    cyc_d = '0;
                    if (pass_q == PASS_LAST) begin
                        state_d = S_FIN;
                        pass_d  = '0;
                    end else begin
                        state_d = S_CMP;
                        pass_d  = pass_q + PW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_FIN: begin
                ovr_d = DSI;
                if (cyc_q == CYC_FIN_LAST) begin
                    state_d = S_DONE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                pass_d  = '0;
            end
        endcase
    end

    // Output decode; reset forces the idle pattern regardless of the registered state.
    always_comb begin
        MED_DSI = 1'b0;
        MED_BYP = 1'b1;
        DSO     = 1'b0;
        BUSY    = 1'b0;
        ERR     = 1'b0;
        OVR     = 1'b0;
        if (RST) begin
            MED_BYP = 1'b1;
        end else begin
            ERR = err_q;
            OVR = ovr_q;
            case (state_q)
                S_IDLE: begin
                    MED_DSI = DSI;
                    BUSY    = DSI;
                end
                S_LOAD: begin
                    MED_DSI = DSI;
                    BUSY    = 1'b1;
                end
                S_CMP, S_FIN: begin
                    MED_BYP = 1'b0;
                    BUSY    = 1'b1;
                end
                S_SHF: begin
                    BUSY = 1'b1;
                end
                S_DONE: begin
                    MED_DSI = DSI;
                    DSO     = 1'b1;
                    BUSY    = 1'b1;
                end
                default: begin
                    MED_BYP = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_med_seq.sv
// Directed bench for med_seq: a table of frame scenarios checked cycle by cycle,
// plus hand-written reset, BYP-trace and N=3 sequences.
module tb_med_seq;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic DSI = 1'b0;
    logic MED_DSI, MED_BYP, DSO, BUSY, ERR, OVR;
    logic MED_DSI_3, MED_BYP_3, DSO_3, BUSY_3, ERR_3, OVR_3;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    med_seq #(.N(9)) dut9 (
        .CLK(CLK), .RST(RST), .DSI(DSI),
        .MED_DSI(MED_DSI), .MED_BYP(MED_BYP), .DSO(DSO),
        .BUSY(BUSY), .ERR(ERR), .OVR(OVR)
    );

    med_seq #(.N(3)) dut3 (
        .CLK(CLK), .RST(RST), .DSI(DSI),
        .MED_DSI(MED_DSI_3), .MED_BYP(MED_BYP_3), .DSO(DSO_3),
        .BUSY(BUSY_3), .ERR(ERR_3), .OVR(OVR_3)
    );

    // Cycle numbers are relative to the start of each vector; cycles 0..1 hold RST.
    typedef struct {
        string name;
        int s1, l1;       // first DSI burst: start cycle, length
        int s2, l2;       // second DSI burst
        int pulse;        // single stray DSI cycle
        int rst_at;       // extra one-cycle RST
        int dso1, dso2;   // expected DSO cycles
        int err_at, ovr_at;
        int b1lo, b1hi, b2lo, b2hi;   // expected BUSY windows
    } vec_t;

    localparam int NV = 8;
    localparam int W  = 110;
    vec_t vecs[NV];
    string sig_names[5];

    task automatic run_vec(input vec_t v);
        int  bad_c[5];
        bit  bad_g[5];
        bit  bad_e[5];
        bit  got[5];
        bit  exp_v[5];
        logic d;
        for (int k = 0; k < 5; k++) begin
            bad_c[k] = -1;
            bad_g[k] = 1'b0;
            bad_e[k] = 1'b0;
        end
        for (int c = 0; c < W; c++) begin
            RST = (c < 2) || (c == v.rst_at);
            d = ((c >= v.s1) && (c < v.s1 + v.l1)) ||
                ((c >= v.s2) && (c < v.s2 + v.l2)) || (c == v.pulse);
            DSI = d;
            @(negedge CLK);
            got[0] = DSO;
            got[1] = ERR;
            got[2] = OVR;
            got[3] = BUSY;
            got[4] = MED_DSI;
            exp_v[0] = (c == v.dso1) || (c == v.dso2);
            exp_v[1] = (c == v.err_at);
            exp_v[2] = (c == v.ovr_at);
            exp_v[3] = ((c >= v.b1lo) && (c <= v.b1hi)) || ((c >= v.b2lo) && (c <= v.b2hi));
            exp_v[4] = d && !RST && (c != v.pulse);
            for (int k = 0; k < 5; k++) begin
                if (bad_c[k] < 0 && got[k] != exp_v[k]) begin
                    bad_c[k] = c;
                    bad_g[k] = got[k];
                    bad_e[k] = exp_v[k];
                end
            end
            @(posedge CLK);
            #1;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bad_c[k] >= 0) begin
                failures++;
                $display("FAIL %s %s at cycle %0d got %0b exp %0b",
                         v.name, sig_names[k], bad_c[k], bad_g[k], bad_e[k]);
            end
        end
    endtask

    initial begin
        bit exp_byp[50];
        bit exp_byp3[8];
        int idx;
        logic [5:0] outs;

        sig_names = '{"DSO", "ERR", "OVR", "BUSY", "MED_DSI"};
        //            name          s1 l1  s2 l2 pulse rst dso1 dso2 err ovr b1lo b1hi b2lo b2hi
        vecs[0] = '{"single",       2, 9, -1, 0,  -1, -1,  51,  -1, -1, -1,  2, 51, -1,  -2};
        vecs[1] = '{"back2back",    2, 9, 51, 9,  -1, -1,  51, 100, -1, -1,  2, 51, 51, 100};
        vecs[2] = '{"abort4",       2, 4, 10, 9,  -1, -1,  59,  -1,  7, -1,  2,  6, 10,  59};
        vecs[3] = '{"ovr_sort",     2, 9, -1, 0,  22, -1,  51,  -1, -1, 23,  2, 51, -1,  -2};
        vecs[4] = '{"rst_mid",      2, 9, 37, 9,  -1, 32,  -1,  86, -1, -1,  2, 31, 37,  86};
        vecs[5] = '{"ovr_fin",      2, 9, -1, 0,  49, -1,  51,  -1, -1, 50,  2, 51, -1,  -2};
        vecs[6] = '{"abort8",       2, 8, -1, 0,  -1, -1,  -1,  -1, 11, -1,  2, 10, -1,  -2};
        vecs[7] = '{"done_accept",  2, 9, 51, 1,  -1, -1,  51,  -1, 53, -1,  2, 52, -1,  -2};

        @(posedge CLK);
        #1;

        // Reset state with DSI held high: outputs must show the idle pattern.
        RST = 1'b1;
        DSI = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            outs = {MED_DSI, MED_BYP, DSO, BUSY, ERR, OVR};
            checks++;
            if (outs !== 6'b010000) begin
                failures++;
                $display("FAIL reset_n9 cycle %0d got %b exp %b", c, outs, 6'b010000);
            end
            outs = {MED_DSI_3, MED_BYP_3, DSO_3, BUSY_3, ERR_3, OVR_3};
            checks++;
            if (outs !== 6'b010000) begin
                failures++;
                $display("FAIL reset_n3 cycle %0d got %b exp %b", c, outs, 6'b010000);
            end
            @(posedge CLK);
            #1;
        end

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // BYP trace for N=9: load, four passes of (8-p) zeros + (p+1) ones, four final zeros, DONE.
        idx = 0;
        for (int i = 0; i < 9; i++) begin exp_byp[idx] = 1'b1; idx++; end
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 8 - p; i++) begin exp_byp[idx] = 1'b0; idx++; end
            for (int i = 0; i < p + 1; i++) begin exp_byp[idx] = 1'b1; idx++; end
        end
        for (int i = 0; i < 4; i++) begin exp_byp[idx] = 1'b0; idx++; end
        exp_byp[idx] = 1'b1;

        RST = 1'b1;
        DSI = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        for (int c = 0; c < 50; c++) begin
            DSI = (c < 9);
            @(negedge CLK);
            checks++;
            if (MED_BYP !== exp_byp[c]) begin
                failures++;
                $display("FAIL byp_trace_n9 t0+%0d got %0b exp %0b", c, MED_BYP, exp_byp[c]);
            end
            if (c == 49) begin
                checks++;
                if (DSO !== 1'b1) begin
                    failures++;
                    $display("FAIL dso_n9 t0+49 got %0b exp 1", DSO);
                end
            end
            @(posedge CLK);
            #1;
        end
        DSI = 1'b0;
        @(negedge CLK);
        checks++;
        if ({DSO, BUSY} !== 2'b00) begin
            failures++;
            $display("FAIL after_done_n9 got %b exp 00", {DSO, BUSY});
        end
        @(posedge CLK);
        #1;

        // Smallest legal frame, N=3: 1,1,1 | 0,0,1 | 0 | 1 with DSO at t0+7.
        exp_byp3 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int c = 0; c < 8; c++) begin
            DSI = (c < 3);
            @(negedge CLK);
            checks++;
            if ({MED_BYP_3, DSO_3} !== {exp_byp3[c], (c == 7)}) begin
                failures++;
                $display("FAIL trace_n3 t0+%0d got byp/dso %b exp %b",
                         c, {MED_BYP_3, DSO_3}, {exp_byp3[c], (c == 7)});
            end
            @(posedge CLK);
            #1;
        end
        DSI = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
